// File: rtl/clk_div_pkg.sv
// Shared constants and table-indexing helper for the clock-divider bank.
// The table packs the half-period for [channel][mode] into one wide vector.
package clk_div_pkg;

   localparam int MODE_W    = 2;
   localparam int NUM_MODES = 4;

   localparam logic [27:0] HALF_SCAN   = 28'd524288;    // 2^19
   localparam logic [27:0] HALF_LED_M0 = 28'd33554432;  // 2^25
   localparam logic [27:0] HALF_LED_M1 = 28'd134217728; // 2^27
   localparam logic [27:0] HALF_LED_M2 = 28'd16777216;  // 2^24
   localparam logic [27:0] HALF_LED_M3 = 28'd67108864;  // 2^26

   // Bit offset of entry [ch][mode] inside the packed half-period table.
   function automatic int tbl_idx(input int ch, input int mode, input int cnt_w);
      return (ch * NUM_MODES + mode) * cnt_w;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: square wave, full-period tick, and a mode that only
// switches at the end of a full period so no half-period is ever truncated.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int CNT_W = 28
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       sync_clr,
   input  logic [MODE_W-1:0]          mode_i,
   input  logic [NUM_MODES*CNT_W-1:0] half_tbl_i,
   output logic                       sq_o,
   output logic                       tick_o,
   output logic [MODE_W-1:0]          mode_act_o
);

   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_half;
   logic              r_sq;
   logic              r_tick;
   logic [MODE_W-1:0] r_mode;

   logic [CNT_W-1:0]  w_half_sel;
   logic              w_wrap;

   assign w_half_sel = half_tbl_i[tbl_idx(0, int'(mode_i), CNT_W) +: CNT_W];
   assign w_wrap     = (r_cnt == r_half - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n || sync_clr) begin
         r_cnt  <= '0;
         r_sq   <= 1'b0;
         r_tick <= 1'b0;
         r_mode <= mode_i;
         r_half <= w_half_sel;
      end else if (!en) begin
         r_tick <= 1'b0;
      end else if (!w_wrap) begin
         r_cnt  <= r_cnt + CNT_W'(1);
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= '0;
         r_sq   <= ~r_sq;
         r_tick <= ~r_sq;
         // Falling edge closes a full period: only here may the mode change.
         if (r_sq) begin
            r_mode <= mode_i;
            r_half <= w_half_sel;
         end
      end
   end

   assign sq_o       = r_sq;
   assign tick_o     = r_tick;
   assign mode_act_o = r_mode;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent clock-divider channels sharing clock, reset, run
// enable and phase-align clear.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int CNT_W  = 28,
   parameter int NUM_CH = 2,
   parameter logic [NUM_CH*NUM_MODES*CNT_W-1:0] HALF_TABLE = {
      HALF_LED_M3, HALF_LED_M2, HALF_LED_M1, HALF_LED_M0,
      HALF_SCAN,   HALF_SCAN,   HALF_SCAN,   HALF_SCAN
   }
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     sync_clr,
   input  logic [MODE_W*NUM_CH-1:0] mode_i,
   output logic [NUM_CH-1:0]        sq_o,
   output logic [NUM_CH-1:0]        tick_o,
   output logic [MODE_W*NUM_CH-1:0] mode_act_o
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_chk_ch
      for (genvar m = 0; m < NUM_MODES; m++) begin : g_chk_mode
         if (HALF_TABLE[tbl_idx(c, m, CNT_W) +: CNT_W] == '0) begin : g_bad
            $error("clk_div_bank: zero half-period in HALF_TABLE entry");
         end
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      clk_div_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .en         (en),
         .sync_clr   (sync_clr),
         .mode_i     (mode_i[MODE_W*k +: MODE_W]),
         .half_tbl_i (HALF_TABLE[tbl_idx(k, 0, CNT_W) +: NUM_MODES*CNT_W]),
         .sq_o       (sq_o[k]),
         .tick_o     (tick_o[k]),
         .mode_act_o (mode_act_o[MODE_W*k +: MODE_W])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: directed scenarios followed by random stimulus,
// all checked against a period-position reference model.
module tb_clk_div_bank;

   localparam int CNT_W  = 8;
   localparam int NUM_CH = 2;
   localparam logic [NUM_CH*4*CNT_W-1:0] TBL = {
      8'd4, 8'd3, 8'd2, 8'd1,
      8'd5, 8'd4, 8'd3, 8'd2
   };

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic       sync_clr = 1'b0;
   logic [3:0] mode_i = '0;
   logic [1:0] sq_o;
   logic [1:0] tick_o;
   logic [3:0] mode_act_o;

   clk_div_bank #(
      .CNT_W      (CNT_W),
      .NUM_CH     (NUM_CH),
      .HALF_TABLE (TBL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .sync_clr   (sync_clr),
      .mode_i     (mode_i),
      .sq_o       (sq_o),
      .tick_o     (tick_o),
      .mode_act_o (mode_act_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference: t is the position inside the current period (0..2h-1);
   // the wave is high for the second half of the period.
   int tbl [2][4] = '{'{2, 3, 4, 5}, '{1, 2, 3, 4}};
   int t [2];
   int h [2];
   logic [1:0] m [2];
   logic [1:0] exp_sq;
   logic [1:0] exp_tick;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_vec++;
      if (obs !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, req, $time);
      end
   endtask

   task automatic model_step();
      for (int c = 0; c < 2; c++) begin
         logic [1:0] md;
         md = mode_i[2*c +: 2];
         if (!rst_n || sync_clr) begin
            t[c] = 0;
            m[c] = md;
            h[c] = tbl[c][md];
            exp_tick[c] = 1'b0;
         end else if (!en) begin
            exp_tick[c] = 1'b0;
         end else begin
            t[c]++;
            exp_tick[c] = (t[c] == h[c]);
            if (t[c] == 2 * h[c]) begin
               t[c] = 0;
               m[c] = md;
               h[c] = tbl[c][md];
            end
         end
         exp_sq[c] = (t[c] >= h[c]);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("sq_o", 32'(sq_o), 32'(exp_sq));
      chk("tick_o", 32'(tick_o), 32'(exp_tick));
      chk("mode_act_o", 32'(mode_act_o), 32'({m[1], m[0]}));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_ch0(input logic lvl, input string tag);
      for (int i = 0; i < 30; i++) begin
         if (sq_o[0] === lvl) break;
         cycle();
      end
      chk(tag, 32'(sq_o[0]), 32'(lvl));
   endtask

   initial begin
      // Reset and free run
      rst_n = 1'b0; en = 1'b1; sync_clr = 1'b0; mode_i = 4'h0;
      run(2);
      chk("rst_sq", 32'(sq_o), 0);
      chk("rst_mode", 32'(mode_act_o), 0);
      rst_n = 1'b1;
      run(1);
      chk("ch0_low_e1", 32'(sq_o[0]), 0);
      run(1);
      chk("ch0_high_e2", 32'(sq_o[0]), 1);
      chk("ch0_tick_e2", 32'(tick_o[0]), 1);
      run(10);

      // Mode change one cycle into the high half
      wait_ch0(1'b0, "wait_lo_a");
      wait_ch0(1'b1, "wait_hi_a");
      cycle();
      mode_i[1:0] = 2'd3;
      run(24);
      chk("mode3_act", 32'(mode_act_o[1:0]), 3);
      mode_i[1:0] = 2'd0;
      run(12);

      // Pause mid low-half
      wait_ch0(1'b1, "wait_hi_b");
      wait_ch0(1'b0, "wait_lo_b");
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("pause_tick", 32'(tick_o), 0);
      end
      en = 1'b1;
      run(10);

      // Phase align with matching halves
      wait_ch0(1'b1, "wait_hi_c");
      mode_i = 4'b0100;
      sync_clr = 1'b1;
      cycle();
      chk("clr_sq", 32'(sq_o), 0);
      chk("clr_tick", 32'(tick_o), 0);
      sync_clr = 1'b0;
      run(12);

      // Priority: clear beats pause, reset beats clear
      en = 1'b0; sync_clr = 1'b1;
      cycle();
      chk("clr_vs_en_sq", 32'(sq_o), 0);
      en = 1'b1; sync_clr = 1'b0;
      run(7);
      rst_n = 1'b0; sync_clr = 1'b1; mode_i = 4'b1110;
      cycle();
      chk("rst_reload_mode", 32'(mode_act_o), 32'h0e);
      rst_n = 1'b1; sync_clr = 1'b0;
      run(9);

      // Mode toggled and restored inside one period
      mode_i = 4'b0000; sync_clr = 1'b1;
      cycle();
      sync_clr = 1'b0;
      cycle();
      mode_i[1:0] = 2'd2;
      cycle();
      mode_i[1:0] = 2'd0;
      run(12);
      chk("toggle_mode", 32'(mode_act_o[1:0]), 0);

      // Random stimulus
      for (int i = 0; i < 3000; i++) begin
         rst_n    = ($urandom_range(0, 199) != 0);
         sync_clr = ($urandom_range(0, 99) < 2);
         en       = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 9) == 0) mode_i = 4'($urandom);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
